seg_clock_scan: RTL

SEG_CLOCK_SCAN -- requirements
Module: seg_clock_scan

---
 rtl/seg_pkg.sv | 39 +++
 rtl/seg_decode.sv | 34 +++
 rtl/seg_clock_scan.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment clock display.
//   DIG_NUM  : number of scanned digits
//   SEG_0..9 : active-low segment codes, common anode, dp off (bit 7 = dp, bits 6:0 = g..a)
//   SEG_OFF  : all segments dark
//   SEL_OFF  : no digit selected (active-low select)
//   time_t   : packed BCD time, MSB first {h10, h1, m10, m1, s10, s1}
package seg_pkg;

  localparam int unsigned DIG_NUM = 6;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [5:0] SEL_OFF = 6'h3F;

  typedef struct packed {
    logic [3:0] h10;
    logic [3:0] h1;
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } time_t;

  // Decimal points separate HH.MM.SS: lit after the H1 and M1 digits.
  function automatic logic dp_lit(input logic [2:0] idx);
    return (idx == 3'd2) || (idx == 3'd4);
  endfunction

endpackage

// File: rtl/seg_decode.sv
// BCD digit to seven-segment decoder (combinational).
//   bcd : 4-bit BCD digit; values above 9 blank the digit
//   dp  : 1 lights the decimal point
//   seg : active-low segments, seg[7] = dp, seg[6:0] = g..a
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] code;

  always_comb begin
    code = SEG_OFF;
    case (bcd)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_OFF;
    endcase
  end

  assign seg = {code[7] & ~dp, code[6:0]};

endmodule

// File: rtl/seg_clock_scan.sv
// HH:MM:SS BCD clock with a multiplexed six-digit seven-segment display driver.
//   sys_clk  : system clock
//   sys_rst  : synchronous reset, active-high
//   tick_1s  : one-cycle pulse per second; advances time when run is high
//   run      : enables time advance
//   clr      : synchronous clear of time to 00:00:00 (wins over tick_1s)
//   sel      : active-low digit select, sel[0] = rightmost digit (S1)
//   seg      : active-low segments, seg[7] = dp, seg[6:0] = g..a
//   time_bcd : {H10, H1, M10, M1, S10, S1}
//   day_tick : one-cycle pulse on the 23:59:59 -> 00:00:00 wrap
module seg_clock_scan
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_MAX = 50_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        tick_1s,
  input  logic        run,
  input  logic        clr,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic [23:0] time_bcd,
  output logic        day_tick
);

  localparam int unsigned    CntW    = (SCAN_MAX > 1) ? $clog2(SCAN_MAX) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_MAX - 1);
  localparam logic [2:0]      IdxLast = 3'(DIG_NUM - 1);

  // Time keeping
  time_t time_q, time_d;
  logic  day_tick_q, day_tick_d;

  logic s1_end, s10_end, m1_end, m10_end, h_end;
  logic inc_s10, inc_m1, inc_m10, inc_h;

  always_comb begin
    s1_end  = (time_q.s1 == 4'd9);
    s10_end = (time_q.s10 == 4'd5);
    m1_end  = (time_q.m1 == 4'd9);
    m10_end = (time_q.m10 == 4'd5);
    h_end   = (time_q.h10 == 4'd2) && (time_q.h1 == 4'd3);

    // Ripple carry: each digit steps only when all lower digits wrap.
    inc_s10 = s1_end;
    inc_m1  = inc_s10 && s10_end;
    inc_m10 = inc_m1 && m1_end;
    inc_h   = inc_m10 && m10_end;
  end

  always_comb begin
    time_d     = time_q;
    day_tick_d = 1'b0;
    if (clr) begin
      time_d = '0;
    end else if (tick_1s && run) begin
      time_d.s1 = s1_end ? 4'd0 : time_q.s1 + 4'd1;
      if (inc_s10) begin
        time_d.s10 = s10_end ? 4'd0 : time_q.s10 + 4'd1;
      end
      if (inc_m1) begin
        time_d.m1 = m1_end ? 4'd0 : time_q.m1 + 4'd1;
      end
      if (inc_m10) begin
        time_d.m10 = m10_end ? 4'd0 : time_q.m10 + 4'd1;
      end
      if (inc_h) begin
        if (h_end) begin
          time_d.h10 = 4'd0;
          time_d.h1  = 4'd0;
          day_tick_d = 1'b1;
        end else if (time_q.h1 == 4'd9) begin
          time_d.h10 = time_q.h10 + 4'd1;
          time_d.h1  = 4'd0;
        end else begin
          time_d.h1 = time_q.h1 + 4'd1;
        end
      end
    end
  end

  // Display scan: free-running dwell counter and digit index
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            scan_end;

  always_comb begin
    scan_end = (cnt_q == CntLast);
    cnt_d    = scan_end ? '0 : cnt_q + CntW'(1);
    idx_d    = idx_q;
    if (scan_end) begin
      idx_d = (idx_q == IdxLast) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Digit select and segment pattern for the current index
  logic [3:0] dig;
  logic       dp;
  logic [5:0] sel_d, sel_q;
  logic [7:0] seg_d, seg_q;

  always_comb begin
    dig = 4'd0;
    case (idx_q)
      3'd0:    dig = time_q.s1;
      3'd1:    dig = time_q.s10;
      3'd2:    dig = time_q.m1;
      3'd3:    dig = time_q.m10;
      3'd4:    dig = time_q.h1;
      3'd5:    dig = time_q.h10;
      default: dig = 4'd0;
    endcase
    dp    = dp_lit(idx_q);
    sel_d = ~(6'b000001 << idx_q);
  end

  seg_decode u_seg_decode (
    .bcd (dig),
    .dp  (dp),
    .seg (seg_d)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      time_q     <= '0;
      day_tick_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      sel_q      <= SEL_OFF;
      seg_q      <= SEG_OFF;
    end else begin
      time_q     <= time_d;
      day_tick_q <= day_tick_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign sel      = sel_q;
  assign seg      = seg_q;
  assign time_bcd = time_q;
  assign day_tick = day_tick_q;

endmodule
